// File: rtl/halfduplex_pin_ctrl_pkg.sv
// Shared types and constants for the half-duplex pin controller:
// FSM state encoding, data-bit count and a TX-state helper.
package halfduplex_pin_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_TX_START = 4'd1,
        ST_TX_DATA  = 4'd2,
        ST_TX_STOP  = 4'd3,
        ST_TURN     = 4'd4,
        ST_RX_WAIT  = 4'd5,
        ST_RX_START = 4'd6,
        ST_RX_DATA  = 4'd7,
        ST_RX_STOP  = 4'd8
    } state_t;

    localparam int         DATA_BITS     = 8;
    localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);

    // The pad is only ever driven while one of the TX states is active.
    function automatic logic is_tx_state(input state_t s);
        return (s == ST_TX_START) || (s == ST_TX_DATA) || (s == ST_TX_STOP);
    endfunction

endpackage

// File: rtl/halfduplex_pin_ctrl_pin_sync.sv
// Two-flop synchronizer for the asynchronous pad input. Resets to 1 so the
// idle (pulled-up) line never looks like a start bit coming out of reset.
module pin_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the raw pin level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/halfduplex_pin_ctrl.sv
// Half-duplex 8N1 engine for one bidirectional pad: sends one byte, then
// optionally releases the pin and receives one response byte with timeout.
// All outputs are registered; next-state and next-output values come from a
// single combinational process.
module halfduplex_pin_ctrl
    import halfduplex_pin_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int TURN_CYCLES  = 2,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       expect_rx,
    output logic       tx_ready,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_timeout,
    output logic       pad_o,
    output logic       pad_t,
    input  logic       pad_i
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    state_t              r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt,   w_cnt_d;
    logic [2:0]          r_bit,   w_bit_d;
    logic [TURN_W-1:0]   r_turn,  w_turn_d;
    logic [TO_W-1:0]     r_to,    w_to_d;
    logic                r_expect, w_expect_d;
    logic                r_pad_t, w_pad_t_d;
    logic                r_pad_o, w_pad_o_d;
    logic                r_tx_ready, w_tx_ready_d;
    logic                r_busy,  w_busy_d;
    logic [7:0]          r_rx_data, w_rx_data_d;
    logic                r_rx_valid, w_rx_valid_d;
    logic                r_rx_ferr,  w_rx_ferr_d;
    logic                r_rx_tout,  w_rx_tout_d;
    logic [7:0]          r_tx_shift;
    logic [7:0]          r_rx_shift;
    logic                w_tx_load;
    logic                w_tx_shift_en;
    logic                w_rx_shift_en;
    logic                w_bit_end;
    logic                w_pin_s;
    logic [TO_W-1:0]     w_to_sat;

    pin_sync u_pin_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (pad_i),
        .o_q   (w_pin_s)
    );

    // Next-state, counter and registered-output logic for the whole transaction.
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_bit_d       = r_bit;
        w_turn_d      = r_turn;
        w_to_d        = r_to;
        w_expect_d    = r_expect;
        w_pad_o_d     = r_pad_o;
        w_rx_data_d   = r_rx_data;
        w_rx_valid_d  = 1'b0;
        w_rx_ferr_d   = 1'b0;
        w_rx_tout_d   = 1'b0;
        w_tx_load     = 1'b0;
        w_tx_shift_en = 1'b0;
        w_rx_shift_en = 1'b0;
        w_bit_end     = (r_cnt == CNT_LAST);
        // Timeout cycle count keeps running through a false start but must not wrap.
        w_to_sat      = (r_to == TO_LAST) ? r_to : r_to + 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (tx_valid && r_tx_ready) begin
                    w_state_d  = ST_TX_START;
                    w_cnt_d    = '0;
                    w_expect_d = expect_rx;
                    w_tx_load  = 1'b1;
                    w_pad_o_d  = 1'b0;
                end
            end
            ST_TX_START: begin
                if (w_bit_end) begin
                    w_state_d = ST_TX_DATA;
                    w_cnt_d   = '0;
                    w_bit_d   = '0;
                    w_pad_o_d = r_tx_shift[0];
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            ST_TX_DATA: begin
                if (w_bit_end) begin
                    w_cnt_d = '0;
                    if (r_bit == LAST_DATA_BIT) begin
                        w_state_d = ST_TX_STOP;
                        w_pad_o_d = 1'b1;
                    end else begin
                        w_bit_d       = r_bit + 1'b1;
                        w_tx_shift_en = 1'b1;
                        w_pad_o_d     = r_tx_shift[1];
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            ST_TX_STOP: begin
                if (w_bit_end) begin
                    w_cnt_d  = '0;
                    w_turn_d = '0;
                    w_state_d = r_expect ? ST_TURN : ST_IDLE;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            ST_TURN: begin
                if (r_turn == TURN_LAST) begin
                    w_state_d = ST_RX_WAIT;
                    w_cnt_d   = '0;
                    w_to_d    = '0;
                end else begin
                    w_turn_d = r_turn + 1'b1;
                end
            end
            ST_RX_WAIT: begin
                if (!w_pin_s) begin
                    w_state_d = ST_RX_START;
                    w_cnt_d   = '0;
                    w_to_d    = w_to_sat;
                end else if (r_to == TO_LAST) begin
                    w_state_d   = ST_IDLE;
                    w_rx_tout_d = 1'b1;
                end else begin
                    w_to_d = r_to + 1'b1;
                end
            end
            ST_RX_START: begin
                w_to_d = w_to_sat;
                if (r_cnt == CNT_HALF) begin
                    w_cnt_d = '0;
                    if (w_pin_s) begin
                        w_state_d = ST_RX_WAIT;
                    end else begin
                        w_state_d = ST_RX_DATA;
                        w_bit_d   = '0;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            ST_RX_DATA: begin
                if (w_bit_end) begin
                    w_cnt_d       = '0;
                    w_rx_shift_en = 1'b1;
                    if (r_bit == LAST_DATA_BIT) begin
                        w_state_d = ST_RX_STOP;
                    end else begin
                        w_bit_d = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            ST_RX_STOP: begin
                if (w_bit_end) begin
                    w_cnt_d   = '0;
                    w_state_d = ST_IDLE;
                    if (w_pin_s) begin
                        w_rx_data_d  = r_rx_shift;
                        w_rx_valid_d = 1'b1;
                    end else begin
                        w_rx_ferr_d = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Pad outputs and handshake follow the state being entered, so the pin
        // is released on the same edge that leaves the TX states.
        w_pad_t_d = !is_tx_state(w_state_d);
        if (w_pad_t_d) begin
            w_pad_o_d = 1'b1;
        end
        w_tx_ready_d = (w_state_d == ST_IDLE);
        w_busy_d     = (w_state_d != ST_IDLE);
    end

    // Control state, counters and registered outputs; reset releases the pin at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_turn     <= '0;
            r_to       <= '0;
            r_expect   <= 1'b0;
            r_pad_t    <= 1'b1;
            r_pad_o    <= 1'b1;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_tout  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_bit      <= w_bit_d;
            r_turn     <= w_turn_d;
            r_to       <= w_to_d;
            r_expect   <= w_expect_d;
            r_pad_t    <= w_pad_t_d;
            r_pad_o    <= w_pad_o_d;
            r_tx_ready <= w_tx_ready_d;
            r_busy     <= w_busy_d;
            r_rx_data  <= w_rx_data_d;
            r_rx_valid <= w_rx_valid_d;
            r_rx_ferr  <= w_rx_ferr_d;
            r_rx_tout  <= w_rx_tout_d;
        end
    end

    // TX and RX shift registers; contents are only meaningful inside a frame.
    always_ff @(posedge clk) begin
        if (w_tx_load) begin
            r_tx_shift <= tx_data;
        end else if (w_tx_shift_en) begin
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
        end
        if (w_rx_shift_en) begin
            r_rx_shift <= {w_pin_s, r_rx_shift[7:1]};
        end
    end

    assign tx_ready     = r_tx_ready;
    assign busy         = r_busy;
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_ferr;
    assign rx_timeout   = r_rx_tout;
    assign pad_o        = r_pad_o;
    assign pad_t        = r_pad_t;

endmodule

// File: tb/tb_halfduplex_pin_ctrl.sv
// Directed bench for halfduplex_pin_ctrl with CLKS_PER_BIT=4, TURN_CYCLES=2,
// TIMEOUT_BITS=4. The pin is modelled as a pulled-up wire the bench can pull
// low while the DUT has released it.
module tb_halfduplex_pin_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       expect_rx;
    logic       tx_ready;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_timeout;
    logic       pad_o;
    logic       pad_t;
    logic       pad_i;

    logic       drv;
    logic       drv_en;

    int n_tests;
    int n_fail;
    int n_valid;
    int n_ferr;
    int n_tout;
    int n_viol;

    halfduplex_pin_ctrl #(
        .CLKS_PER_BIT (4),
        .TURN_CYCLES  (2),
        .TIMEOUT_BITS (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .expect_rx    (expect_rx),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_timeout   (rx_timeout),
        .pad_o        (pad_o),
        .pad_t        (pad_t),
        .pad_i        (pad_i)
    );

    assign pad_i = pad_t ? drv : pad_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count result pulses and record illegal pin/handshake combinations.
    always @(negedge clk) begin
        if (rx_valid === 1'b1)     n_valid++;
        if (rx_frame_err === 1'b1) n_ferr++;
        if (rx_timeout === 1'b1)   n_tout++;
        if ((int'(rx_valid === 1'b1) + int'(rx_frame_err === 1'b1) + int'(rx_timeout === 1'b1)) > 1) n_viol++;
        if (pad_t === 1'b0 && busy !== 1'b1) n_viol++;
        if (pad_t === 1'b0 && tx_ready !== 1'b0) n_viol++;
        if (pad_t === 1'b0 && drv_en) n_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_tx(input logic [7:0] d, input logic erx);
        @(posedge clk);
        #1;
        tx_data   = d;
        expect_rx = erx;
        tx_valid  = 1'b1;
        @(posedge clk);
        #1;
        tx_valid  = 1'b0;
    endtask

    // Checks the 40-cycle driven frame; pokes tx_valid mid-frame, which must be ignored.
    task automatic check_tx_frame(input logic [7:0] d, input logic erx, input string tag);
        logic [9:0] frame;
        int         n_drive;
        frame   = {1'b1, d, 1'b0};
        n_drive = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pad_t === 1'b0) n_drive++;
            if (c == 10) begin
                tx_valid  = 1'b1;
                tx_data   = ~d;
                expect_rx = ~erx;
            end
            if (c == 12) begin
                tx_valid  = 1'b0;
                tx_data   = d;
                expect_rx = erx;
            end
            if (c % 4 == 2) chk($sformatf("%s_bit%0d", tag, c / 4), {31'd0, pad_o}, {31'd0, frame[c / 4]});
        end
        chk({tag, "_drive_cycles"}, n_drive, 40);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        drv_en = 1'b1;
        drv    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            drv = d[i];
            repeat (4) @(posedge clk);
            #1;
        end
        drv = stop;
        repeat (4) @(posedge clk);
        #1;
        drv    = 1'b1;
        drv_en = 1'b0;
    endtask

    initial begin
        logic seen;
        logic early;
        int   v0, f0, t0;

        n_tests   = 0;
        n_fail    = 0;
        n_valid   = 0;
        n_ferr    = 0;
        n_tout    = 0;
        n_viol    = 0;
        reset     = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        expect_rx = 1'b0;
        drv       = 1'b1;
        drv_en    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pad_t",    {31'd0, pad_t},    32'd1);
        chk("rst_pad_o",    {31'd0, pad_o},    32'd1);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_rx_data",  {24'd0, rx_data},  32'h00);
        chk("rst_pulses",   {29'd0, rx_valid, rx_frame_err, rx_timeout}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // TX only, 8'hA5
        send_tx(8'hA5, 1'b0);
        check_tx_frame(8'hA5, 1'b0, "txA5");
        @(negedge clk);
        chk("txA5_release_pad_t", {31'd0, pad_t},    32'd1);
        chk("txA5_tx_ready",      {31'd0, tx_ready}, 32'd1);
        chk("txA5_busy",          {31'd0, busy},     32'd0);
        chk("txA5_no_rx_pulses",  n_valid + n_ferr + n_tout, 32'd0);

        // TX 8'h3C then receive 8'hC3
        send_tx(8'h3C, 1'b1);
        check_tx_frame(8'h3C, 1'b1, "tx3C");
        @(negedge clk);
        chk("turn_pad_t",    {31'd0, pad_t},    32'd1);
        chk("turn_busy",     {31'd0, busy},     32'd1);
        chk("turn_tx_ready", {31'd0, tx_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        v0 = n_valid;
        drive_frame(8'hC3, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rxC3_valid_seen", {31'd0, seen},     32'd1);
        chk("rxC3_data",       {24'd0, rx_data},  32'hC3);
        chk("rxC3_busy_fall",  {31'd0, busy},     32'd0);
        chk("rxC3_tx_ready",   {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        chk("rxC3_pulse_end",  {31'd0, rx_valid}, 32'd0);
        chk("rxC3_one_valid",  n_valid - v0,      32'd1);
        chk("rxC3_no_err",     n_ferr + n_tout,   32'd0);

        // Timeout with the pin left high
        send_tx(8'h00, 1'b1);
        check_tx_frame(8'h00, 1'b1, "tx00");
        @(negedge clk);
        t0    = n_tout;
        early = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            early = early | (rx_timeout === 1'b1);
        end
        chk("to_not_early", {31'd0, early}, 32'd0);
        @(negedge clk);
        chk("to_pulse",     {31'd0, rx_timeout}, 32'd1);
        chk("to_busy",      {31'd0, busy},       32'd0);
        @(negedge clk);
        chk("to_pulse_end", {31'd0, rx_timeout}, 32'd0);
        chk("to_count",     n_tout - t0,         32'd1);
        chk("to_rx_data",   {24'd0, rx_data},    32'hC3);

        // False start glitch, then a frame with a low stop bit
        send_tx(8'h81, 1'b1);
        check_tx_frame(8'h81, 1'b1, "tx81");
        @(negedge clk);
        v0 = n_valid;
        f0 = n_ferr;
        t0 = n_tout;
        repeat (3) @(posedge clk);
        #1;
        drv_en = 1'b1;
        drv    = 1'b0;
        @(posedge clk);
        #1;
        drv    = 1'b1;
        drv_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("fs_still_busy", {31'd0, busy}, 32'd1);
        chk("fs_no_pulse",   (n_valid - v0) + (n_ferr - f0) + (n_tout - t0), 32'd0);
        drive_frame(8'h96, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rx_frame_err === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ferr_seen",     {31'd0, seen},  32'd1);
        chk("ferr_busy",     {31'd0, busy},  32'd0);
        chk("ferr_rx_data",  {24'd0, rx_data}, 32'hC3);
        @(negedge clk);
        chk("ferr_pulse_end", {31'd0, rx_frame_err}, 32'd0);
        chk("ferr_count",     n_ferr - f0, 32'd1);
        chk("ferr_no_other",  (n_valid - v0) + (n_tout - t0), 32'd0);

        // Reset in the middle of data bit 3 (fifth bit period)
        send_tx(8'hE7, 1'b0);
        repeat (17) @(negedge clk);
        chk("mid_tx_driving", {31'd0, pad_t}, 32'd0);
        reset = 1'b1;
        #1;
        chk("async_rst_pad_t",    {31'd0, pad_t},    32'd1);
        chk("async_rst_pad_o",    {31'd0, pad_o},    32'd1);
        chk("async_rst_busy",     {31'd0, busy},     32'd0);
        chk("async_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("post_rst_pad_t",    {31'd0, pad_t},    32'd1);
        send_tx(8'h5A, 1'b0);
        check_tx_frame(8'h5A, 1'b0, "tx5A");
        @(negedge clk);
        chk("tx5A_release_pad_t", {31'd0, pad_t},    32'd1);
        chk("tx5A_tx_ready",      {31'd0, tx_ready}, 32'd1);
        chk("tx5A_rx_data_kept",  {24'd0, rx_data},  32'h00);

        // Whole-run pin and pulse invariants
        chk("invariant_violations", n_viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
